// File: rtl/seg7_mux_driver_pkg.sv
// Shared types and decode table for the multiplexed 7-segment driver.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package seg7_mux_driver_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_DEAD,
    ST_ON,
    ST_OFF
  } state_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_mux_driver_if.sv
// Value/control inputs and display pins of the 7-segment driver.
// master = upstream logic driving values, slave = the driver itself.
interface seg7_mux_driver_if;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load;
  logic [3:0]  brightness;
  logic        lzb;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_tick;

  modport master (
    output value_in, dp_in, load, brightness, lzb,
    input  seg_n, dp_n, an_n, frame_tick
  );

  modport slave (
    input  value_in, dp_in, load, brightness, lzb,
    output seg_n, dp_n, an_n, frame_tick
  );
endinterface

// File: rtl/seg7_mux_driver_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
// Reusable by any display block needing the same glyphs.
module seg7_hex_decode
  import seg7_mux_driver_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = hex_to_seg(i_hex);

endmodule

// File: rtl/seg7_mux_driver.sv
// 4-digit common-anode multiplexer with dead time, 16-level PWM,
// leading-zero blanking and frame-aligned double buffering.
module seg7_mux_driver
  import seg7_mux_driver_pkg::*;
#(
  parameter int CLK_HZ      = 25_000_000,
  parameter int REFRESH_HZ  = 1000,
  parameter int DEAD_CYCLES = 64
) (
  input  logic         i_clock,
  input  logic         i_reset,
  seg7_mux_driver_if.slave bus
);

  localparam int SLOT = CLK_HZ / (REFRESH_HZ * 4);
  localparam int STEP = (SLOT - DEAD_CYCLES) / 16;
  localparam int CW   = $clog2(SLOT);

  localparam logic [CW-1:0] LAST     = CW'(SLOT - 1);
  localparam logic [CW-1:0] DEAD_END = CW'(DEAD_CYCLES - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;

  logic [15:0] r_pend_val;
  logic [3:0]  r_pend_dp;
  logic        r_dirty;
  logic [15:0] r_val;
  logic [3:0]  r_dp;
  logic [3:0]  r_bri;
  logic        r_lzb;

  logic [6:0] r_seg_n;
  logic       r_dp_n;
  logic [3:0] r_an_n;
  logic       r_tick;

  logic [31:0] w_on_end;
  logic [31:0] w_cnt_inc;
  logic        w_bound;
  logic [3:0]  w_nib;
  logic [6:0]  w_dec;
  logic        w_zero_above;
  logic [6:0]  w_seg_pat;

  assign w_on_end  = 32'(DEAD_CYCLES) + 32'(r_bri) * 32'(STEP);
  assign w_cnt_inc = 32'(r_cnt) + 32'd1;
  assign w_bound   = (r_idx == 2'd0) && (r_cnt == '0);
  assign w_nib     = r_val[{r_idx, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .i_hex (w_nib),
    .o_seg (w_dec)
  );

  // A digit is blank only if it and every digit above it are zero.
  always_comb begin
    w_zero_above = 1'b0;
    unique case (r_idx)
      2'd3:    w_zero_above = (r_val[15:12] == 4'h0);
      2'd2:    w_zero_above = (r_val[15:8] == 8'h00);
      2'd1:    w_zero_above = (r_val[15:4] == 12'h000);
      default: w_zero_above = 1'b0;
    endcase
  end

  assign w_seg_pat = (r_lzb && w_zero_above) ? SEG_BLANK : w_dec;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_DEAD:
        if (r_cnt == DEAD_END)
          w_state_nxt = (r_bri == 4'd0) ? ST_OFF : ST_ON;
      ST_ON:
        if (w_cnt_inc == w_on_end)
          w_state_nxt = ST_OFF;
      ST_OFF:
        if (r_cnt == LAST)
          w_state_nxt = ST_DEAD;
      default: w_state_nxt = ST_DEAD;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_DEAD;
      r_cnt   <= '0;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      if (r_cnt == LAST)
        r_idx <= r_idx + 1'b1;
    end
  end

  // Outputs lag the counters by one cycle, so the release edge
  // emits the first DEAD cycle of digit 0 together with frame_tick.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_seg_n <= SEG_BLANK;
      r_dp_n  <= 1'b1;
      r_an_n  <= 4'hF;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= w_bound;
      r_an_n <= (r_state == ST_ON) ? ~(4'b0001 << r_idx) : 4'hF;
      if (r_state == ST_DEAD) begin
        r_seg_n <= w_seg_pat;
        r_dp_n  <= ~r_dp[r_idx];
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_dirty    <= 1'b0;
      r_val      <= '0;
      r_dp       <= '0;
      r_bri      <= '0;
      r_lzb      <= 1'b0;
    end else begin
      if (bus.load) begin
        r_pend_val <= bus.value_in;
        r_pend_dp  <= bus.dp_in;
      end
      // A load on the boundary edge stays pending for the next frame.
      if (w_bound) begin
        if (r_dirty) begin
          r_val <= r_pend_val;
          r_dp  <= r_pend_dp;
        end
        r_bri   <= bus.brightness;
        r_lzb   <= bus.lzb;
        r_dirty <= bus.load;
      end else if (bus.load) begin
        r_dirty <= 1'b1;
      end
    end
  end

  assign bus.seg_n      = r_seg_n;
  assign bus.dp_n       = r_dp_n;
  assign bus.an_n       = r_an_n;
  assign bus.frame_tick = r_tick;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Directed bench for seg7_mux_driver at SLOT=40, DEAD=8, STEP=2.
// Frames are captured tick-to-tick and analysed per digit.
module tb_seg7_mux_driver;

  localparam int FRAME = 160;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  logic chk_en   = 1'b0;
  logic [6:0] prev_seg = 7'h7F;

  logic [3:0] c_an  [FRAME];
  logic [6:0] c_seg [FRAME];
  logic       c_dp  [FRAME];
  logic       c_tick[FRAME];

  seg7_mux_driver_if bus();

  seg7_mux_driver #(
    .CLK_HZ      (1600),
    .REFRESH_HZ  (10),
    .DEAD_CYCLES (8)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk_en && bus.an_n !== 4'hF) begin
      checks++;
      if ($countones(~bus.an_n) != 1 || bus.seg_n !== prev_seg) begin
        failures++;
        $display("FAIL checker an_n=%h seg_n=%h prev_seg=%h",
                 bus.an_n, bus.seg_n, prev_seg);
      end
    end
    prev_seg = bus.seg_n;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] dp);
    bus.value_in = v;
    bus.dp_in    = dp;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load     = 1'b0;
  endtask

  task automatic wait_tick(input int budget, output int waited);
    waited = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.frame_tick === 1'b1) begin
        waited = i;
        break;
      end
    end
    checks++;
    if (waited == 0) begin
      failures++;
      $display("FAIL tick_timeout no frame_tick within %0d cycles", budget);
    end
  endtask

  task automatic capture();
    for (int i = 0; i < FRAME; i++) begin
      c_an[i]   = bus.an_n;
      c_seg[i]  = bus.seg_n;
      c_dp[i]   = bus.dp_n;
      c_tick[i] = bus.frame_tick;
      @(negedge clk);
    end
  endtask

  task automatic digit_stats(input int d, output int n, output int first,
                             output logic [6:0] seg, output logic dp);
    logic [3:0] m;
    m = ~(4'b0001 << d);
    n = 0;
    first = -1;
    seg = 7'bxxxxxxx;
    dp = 1'bx;
    for (int i = 0; i < FRAME; i++) begin
      if (c_an[i] === m) begin
        if (n == 0) begin
          first = i;
          seg = c_seg[i];
          dp = c_dp[i];
        end
        n++;
      end
    end
  endtask

  task automatic test_reset();
    int w;
    bus.value_in = 16'h0;
    bus.dp_in = 4'h0;
    bus.load = 1'b0;
    bus.brightness = 4'd15;
    bus.lzb = 1'b0;
    rst = 1'b1;
    step(3);
    checks += 4;
    if (bus.an_n !== 4'hF) begin
      failures++; $display("FAIL reset_an an_n=%h want F", bus.an_n);
    end
    if (bus.seg_n !== 7'h7F) begin
      failures++; $display("FAIL reset_seg seg_n=%h want 7F", bus.seg_n);
    end
    if (bus.dp_n !== 1'b1) begin
      failures++; $display("FAIL reset_dp dp_n=%b want 1", bus.dp_n);
    end
    if (bus.frame_tick !== 1'b0) begin
      failures++; $display("FAIL reset_tick tick=%b want 0", bus.frame_tick);
    end
    chk_en = 1'b1;
    rst = 1'b0;
    wait_tick(3, w);
    checks++;
    if (w != 1) begin
      failures++; $display("FAIL tick_after_release waited=%0d want 1", w);
    end
  endtask

  task automatic test_frame();
    int n, first, nt;
    logic [6:0] seg;
    logic dp;
    capture();
    nt = 0;
    for (int i = 0; i < FRAME; i++) nt += int'(c_tick[i]);
    checks += 2;
    if (nt != 1 || c_tick[0] !== 1'b1) begin
      failures++; $display("FAIL tick_once count=%0d first=%b want 1/1", nt, c_tick[0]);
    end
    if (bus.frame_tick !== 1'b1) begin
      failures++; $display("FAIL tick_period tick=%b want 1 after 160", bus.frame_tick);
    end
    for (int d = 0; d < 4; d++) begin
      digit_stats(d, n, first, seg, dp);
      checks += 3;
      if (n != 30) begin
        failures++; $display("FAIL on_len d%0d got=%0d want 30", d, n);
      end
      if (first != 40 * d + 8) begin
        failures++; $display("FAIL on_start d%0d got=%0d want %0d", d, first, 40 * d + 8);
      end
      if (seg !== 7'h40) begin
        failures++; $display("FAIL zero_seg d%0d got=%h want 40", d, seg);
      end
    end
  endtask

  task automatic test_load_decode();
    int n, first, w, ndp;
    logic [6:0] seg;
    logic dp;
    logic [6:0] exp_seg [4];
    exp_seg[0] = 7'h0E;
    exp_seg[1] = 7'h08;
    exp_seg[2] = 7'h24;
    exp_seg[3] = 7'h79;
    step(20);
    pulse_load(16'h12AF, 4'b0100);
    wait_tick(200, w);
    capture();
    ndp = 0;
    for (int i = 0; i < FRAME; i++)
      if (c_dp[i] === 1'b0 && c_an[i] !== 4'hF) ndp++;
    checks++;
    if (ndp != 30) begin
      failures++; $display("FAIL dp_lit_cycles got=%0d want 30", ndp);
    end
    for (int d = 0; d < 4; d++) begin
      digit_stats(d, n, first, seg, dp);
      checks += 2;
      if (seg !== exp_seg[d]) begin
        failures++; $display("FAIL decode d%0d got=%h want %h", d, seg, exp_seg[d]);
      end
      if (dp !== (d == 2 ? 1'b0 : 1'b1)) begin
        failures++; $display("FAIL dp d%0d got=%b want %b", d, dp, d != 2);
      end
    end
  endtask

  task automatic test_brightness();
    int n, first, w;
    logic [6:0] seg;
    logic dp;
    int lv [3];
    lv[0] = 0;
    lv[1] = 1;
    lv[2] = 8;
    for (int k = 0; k < 3; k++) begin
      bus.brightness = 4'(lv[k]);
      wait_tick(200, w);
      capture();
      checks++;
      if (bus.frame_tick !== 1'b1) begin
        failures++; $display("FAIL bri_frame_len b=%0d tick=%b want 1", lv[k], bus.frame_tick);
      end
      for (int d = 0; d < 4; d++) begin
        digit_stats(d, n, first, seg, dp);
        checks++;
        if (n != 2 * lv[k]) begin
          failures++; $display("FAIL bri_len b=%0d d%0d got=%0d want %0d", lv[k], d, n, 2 * lv[k]);
        end
        if (lv[k] != 0) begin
          checks++;
          if (first != 40 * d + 8) begin
            failures++; $display("FAIL bri_start b=%0d d%0d got=%0d want %0d", lv[k], d, first, 40 * d + 8);
          end
        end
      end
    end
  endtask

  task automatic test_lzb();
    int n, first, w;
    logic [6:0] seg;
    logic dp;
    bus.lzb = 1'b1;
    pulse_load(16'h0005, 4'b0000);
    wait_tick(200, w);
    capture();
    for (int d = 0; d < 4; d++) begin
      digit_stats(d, n, first, seg, dp);
      checks += 2;
      if (seg !== (d == 0 ? 7'h12 : 7'h7F)) begin
        failures++; $display("FAIL lzb5_seg d%0d got=%h want %h", d, seg, d == 0 ? 7'h12 : 7'h7F);
      end
      if (n != 16) begin
        failures++; $display("FAIL lzb5_len d%0d got=%0d want 16", d, n);
      end
    end
    pulse_load(16'h0000, 4'b0000);
    wait_tick(200, w);
    capture();
    for (int d = 0; d < 4; d++) begin
      digit_stats(d, n, first, seg, dp);
      checks++;
      if (seg !== (d == 0 ? 7'h40 : 7'h7F)) begin
        failures++; $display("FAIL lzb0_seg d%0d got=%h want %h", d, seg, d == 0 ? 7'h40 : 7'h7F);
      end
    end
    bus.lzb = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n, first;
    logic [6:0] seg;
    logic dp;
    step(10);
    pulse_load(16'h1111, 4'h0);
    step(10);
    pulse_load(16'h2222, 4'h0);
    step(137);
    bus.value_in = 16'h3333;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    checks++;
    if (bus.frame_tick !== 1'b1) begin
      failures++; $display("FAIL boundary_align tick=%b want 1", bus.frame_tick);
    end
    capture();
    for (int d = 0; d < 4; d++) begin
      digit_stats(d, n, first, seg, dp);
      checks++;
      if (seg !== 7'h24) begin
        failures++; $display("FAIL last_load_wins d%0d got=%h want 24", d, seg);
      end
    end
    capture();
    for (int d = 0; d < 4; d++) begin
      digit_stats(d, n, first, seg, dp);
      checks++;
      if (seg !== 7'h30) begin
        failures++; $display("FAIL boundary_load d%0d got=%h want 30", d, seg);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, first, w;
    logic [6:0] seg;
    logic dp;
    step(93);
    checks++;
    if (bus.an_n !== 4'b1011) begin
      failures++; $display("FAIL mid_on_d2 an_n=%h want B", bus.an_n);
    end
    rst = 1'b1;
    step(1);
    checks += 4;
    if (bus.an_n !== 4'hF) begin
      failures++; $display("FAIL midrst_an an_n=%h want F", bus.an_n);
    end
    if (bus.seg_n !== 7'h7F) begin
      failures++; $display("FAIL midrst_seg seg_n=%h want 7F", bus.seg_n);
    end
    if (bus.dp_n !== 1'b1) begin
      failures++; $display("FAIL midrst_dp dp_n=%b want 1", bus.dp_n);
    end
    if (bus.frame_tick !== 1'b0) begin
      failures++; $display("FAIL midrst_tick tick=%b want 0", bus.frame_tick);
    end
    step(2);
    rst = 1'b0;
    wait_tick(3, w);
    checks++;
    if (w != 1) begin
      failures++; $display("FAIL restart_tick waited=%0d want 1", w);
    end
    capture();
    digit_stats(0, n, first, seg, dp);
    checks += 3;
    if (first != 8) begin
      failures++; $display("FAIL restart_start got=%0d want 8", first);
    end
    if (n != 16) begin
      failures++; $display("FAIL restart_len got=%0d want 16", n);
    end
    if (seg !== 7'h40) begin
      failures++; $display("FAIL restart_seg got=%h want 40", seg);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_load_decode();
    test_brightness();
    test_lzb();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
